// File: rtl/yurut_sonuc_yolu.sv
// yurut_sonuc_yolu: execute-unit result collection stage.
// Arbitrates completions from KANAL_SAYISI functional units, buffers them in
// a DERINLIK-entry FIFO and presents one write-back per cycle to geri yaz.
// Optional feature: define YURUT_ROUND_ROBIN_EN for round-robin arbitration;
// the default build uses fixed lowest-index priority.
module yurut_sonuc_yolu #(
    parameter int KANAL_SAYISI    = 4,
    parameter int VERI_GENISLIGI  = 32,
    parameter int ADRES_GENISLIGI = 5,
    parameter int DERINLIK        = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [KANAL_SAYISI-1:0]                 kanal_hazir_i,
    input  logic [KANAL_SAYISI*VERI_GENISLIGI-1:0]  kanal_sonuc_i,
    input  logic [KANAL_SAYISI*ADRES_GENISLIGI-1:0] kanal_hedef_i,
    output logic [KANAL_SAYISI-1:0]                 kanal_kabul_o,
    input  logic                                    durdur_i,
    output logic                                    yazmaca_yaz_o,
    output logic [ADRES_GENISLIGI-1:0]              hedef_yazmaci_o,
    output logic [VERI_GENISLIGI-1:0]               hedef_yazmac_verisi_o,
    output logic [$clog2(KANAL_SAYISI)-1:0]         kanal_no_o,
    output logic [$clog2(DERINLIK):0]               doluluk_o,
    output logic                                    yurut_stall_o
);

    localparam int KW = $clog2(KANAL_SAYISI);
    localparam int PW = $clog2(DERINLIK);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] DOLU = DW'(DERINLIK);
    localparam logic [DW-1:0] ESIK = DW'(DERINLIK - 1);

    // FIFO storage; read asynchronously at the head so an accepted entry is
    // visible one cycle after acceptance.
    logic [VERI_GENISLIGI-1:0]  veri_mem  [DERINLIK];
    logic [ADRES_GENISLIGI-1:0] hedef_mem [DERINLIK];
    logic [KW-1:0]              kanal_mem [DERINLIK];

    logic [PW-1:0] bas_reg;
    logic [PW-1:0] kuyruk_reg;
    logic [DW-1:0] doluluk_reg;

    logic [VERI_GENISLIGI-1:0]  sonuc_dizi [KANAL_SAYISI];
    logic [ADRES_GENISLIGI-1:0] hedef_dizi [KANAL_SAYISI];

    logic          bos;
    logic          pop;
    logic          push_izin;
    logic          secim_var;
    logic [KW-1:0] secim_idx;
    logic          kabul_var;
    logic          push;

    // Unpack the flat per-channel buses into arrays indexed by channel.
    generate
        for (genvar gi = 0; gi < KANAL_SAYISI; gi++) begin : g_kanal
            assign sonuc_dizi[gi] = kanal_sonuc_i[gi*VERI_GENISLIGI +: VERI_GENISLIGI];
            assign hedef_dizi[gi] = kanal_hedef_i[gi*ADRES_GENISLIGI +: ADRES_GENISLIGI];
        end
    endgenerate

    assign bos       = (doluluk_reg == '0);
    assign pop       = !bos && !durdur_i;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign push_izin = !rst_i && ((doluluk_reg < DOLU) || pop);

`ifdef YURUT_ROUND_ROBIN_EN
    logic [KW-1:0] son_kanal_reg;
    int            aday_int;
    logic [KW-1:0] aday;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        secim_var = 1'b0;
        secim_idx = '0;
        aday_int  = 0;
        aday      = '0;
        for (int i = 1; i <= KANAL_SAYISI; i++) begin
            aday_int = (int'(son_kanal_reg) + i) % KANAL_SAYISI;
            aday     = KW'(aday_int);
            if (!secim_var && kanal_hazir_i[aday]) begin
                secim_var = 1'b1;
                secim_idx = aday;
            end
        end
    end

    // Remember the last grant, including grants of discarded x0 results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            son_kanal_reg <= KW'(KANAL_SAYISI - 1);
        end else if (kabul_var) begin
            son_kanal_reg <= secim_idx;
        end
    end
`else
    // Fixed priority: scan from the top down so the lowest index wins.
    always_comb begin
        secim_var = 1'b0;
        secim_idx = '0;
        for (int i = KANAL_SAYISI - 1; i >= 0; i--) begin
            if (kanal_hazir_i[KW'(i)]) begin
                secim_var = 1'b1;
                secim_idx = KW'(i);
            end
        end
    end
`endif

    assign kabul_var     = push_izin && secim_var;
    assign kanal_kabul_o = kabul_var ? (KANAL_SAYISI'(1) << secim_idx) : '0;
    // Results aimed at x0 are acknowledged but never stored.
    assign push          = kabul_var && (hedef_dizi[secim_idx] != '0);

    // Pointer and occupancy bookkeeping; reset drops every buffered entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bas_reg     <= '0;
            kuyruk_reg  <= '0;
            doluluk_reg <= '0;
        end else begin
            if (push) begin
                kuyruk_reg <= kuyruk_reg + PW'(1);
            end
            if (pop) begin
                bas_reg <= bas_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   doluluk_reg <= doluluk_reg + DW'(1);
                2'b01:   doluluk_reg <= doluluk_reg - DW'(1);
                default: doluluk_reg <= doluluk_reg;
            endcase
        end
    end

    // Write the accepted entry at the tail.
    always_ff @(posedge clk_i) begin
        if (push) begin
            veri_mem[kuyruk_reg]  <= sonuc_dizi[secim_idx];
            hedef_mem[kuyruk_reg] <= hedef_dizi[secim_idx];
            kanal_mem[kuyruk_reg] <= secim_idx;
        end
    end

    assign yazmaca_yaz_o         = !bos;
    assign hedef_yazmaci_o       = bos ? '0 : hedef_mem[bas_reg];
    assign hedef_yazmac_verisi_o = bos ? '0 : veri_mem[bas_reg];
    assign kanal_no_o            = bos ? '0 : kanal_mem[bas_reg];
    assign doluluk_o             = doluluk_reg;
    assign yurut_stall_o         = (doluluk_reg >= ESIK);

endmodule

// File: doc/yurut_sonuc_yolu.md
# yurut_sonuc_yolu

Parametrised result-collection stage for the execute unit. Accepts completions from KANAL_SAYISI multi-cycle functional units (AMB, yapay zeka, kriptografi, future units), arbitrates one per cycle, buffers them in a small FIFO and presents one write-back per cycle to the geri yaz stage under downstream back-pressure. Replaces the fixed three-way result mux with a handshaked, depth-configurable path that handles simultaneous completions without losing results.

## Interface
- KANAL_SAYISI, 4, number of functional-unit channels (>=2)
- VERI_GENISLIGI, 32, result width
- ADRES_GENISLIGI, 5, destination register index width
- DERINLIK, 4, FIFO depth (power of two, >=2)
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- kanal_hazir_i  input  KANAL_SAYISI  channel k holds result valid; must stay high until kabul
- kanal_sonuc_i  input  KANAL_SAYISI*VERI_GENISLIGI  channel k result at [k*VERI_GENISLIGI +: VERI_GENISLIGI]
- kanal_hedef_i  input  KANAL_SAYISI*ADRES_GENISLIGI  channel k destination register, same packing
- kanal_kabul_o  output  KANAL_SAYISI  one-hot or zero; channel k result taken this cycle
- durdur_i  input  1  geri yaz not ready; head entry must be held
- yazmaca_yaz_o  output  1  head entry valid
- hedef_yazmaci_o  output  ADRES_GENISLIGI  head destination register
- hedef_yazmac_verisi_o  output  VERI_GENISLIGI  head result
- kanal_no_o  output  $clog2(KANAL_SAYISI)  source channel of head entry
- doluluk_o  output  $clog2(DERINLIK)+1  current FIFO occupancy
- yurut_stall_o  output  1  upstream issue stall

## Operation
- Pop: yazmaca_yaz_o && !durdur_i. Push permitted when doluluk < DERINLIK, or when doluluk == DERINLIK and pop occurs this cycle.
- Arbitration (combinational): among asserted kanal_hazir_i select one channel; if push permitted, assert its kanal_kabul_o bit. Otherwise kanal_kabul_o = 0.
- Default policy: fixed priority, lowest index wins.
- Accepted entry with hedef == 0: kabul asserted, entry discarded (not written, doluluk unchanged by it).
- Accepted entry otherwise: {sonuc, hedef, kanal_no} written at tail; tail pointer wraps modulo DERINLIK.
- Head outputs driven from FIFO storage at head pointer; when empty, yazmaca_yaz_o=0 and data/hedef/kanal_no outputs forced to 0.
- Push and pop in same cycle: doluluk unchanged, both pointers advance.
- yurut_stall_o = (doluluk_o >= DERINLIK-1), from registered count.
- Reset (rst_i high at edge): pointers, doluluk, arbitration pointer cleared; kanal_kabul_o = 0 while rst_i high regardless of inputs. Reset values: yazmaca_yaz_o 0, hedef_yazmaci_o 0, hedef_yazmac_verisi_o 0, kanal_no_o 0, doluluk_o 0, yurut_stall_o 0, kanal_kabul_o 0. Reset mid-operation drops all buffered entries.

## Timing
- kanal_kabul_o is combinational from kanal_hazir_i, doluluk and durdur_i, same cycle.
- Latency: accepted at edge N (empty FIFO) -> yazmaca_yaz_o=1 with that entry in cycle after edge N (1 cycle).
- Throughput: one accept and one write-back per cycle.
- Order: write-back order equals acceptance order.
- Channel whose hazir drops before kabul: withdrawn, no entry (protocol violation by producer, not checked).

## Configuration
- YURUT_ROUND_ROBIN_EN defined: round-robin arbitration. Pointer son_kanal (reset KANAL_SAYISI-1); search starts at son_kanal+1 and wraps; son_kanal updated to granted index on every kabul (including discarded x0 grants).
- Not defined: fixed lowest-index priority; no arbitration state.

## Test plan
- Ch2 hazir, sonuc 0xDEADBEEF, hedef 5, FIFO empty -> kanal_kabul_o=4'b0100 same cycle; next cycle yazmaca_yaz_o=1, veri 0xDEADBEEF, hedef 5, kanal_no 2, then empty.
- Ch0,ch1,ch3 held hazir together -> grants 0,1,3 on consecutive cycles; with ch0 and ch3 permanently hazir: fixed gives 0,0,0...; YURUT_ROUND_ROBIN_EN gives 0,3,0,3.
- durdur_i=1, ch1 pushes 4 entries (hedef 1..4) -> doluluk 3 sets yurut_stall_o=1, doluluk 4 forces kabul=0; release durdur_i -> hedef 1,2,3,4 in order one per cycle.
- FIFO full, durdur_i=0, ch0 hazir -> kabul same cycle, doluluk stays 4, head advances.
- Ch1 hazir with hedef 0, sonuc 0x12345678 -> kabul asserted, doluluk stays 0, yazmaca_yaz_o stays 0.
- doluluk 2, ch2 hazir, rst_i=1 for one cycle -> kabul 0 during reset; next cycle all outputs 0, doluluk 0; ch2 accepted the following cycle.
